// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-side memory responder: RV32I load funct3 codes and
// the per-load bookkeeping carried through the read pipeline.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] offset;
    } load_tag_t;

    // One slot of the read pipeline; an idle slot is all zeros.
    typedef struct packed {
        logic        valid;
        logic        addr_err;
        load_tag_t   tag;
        logic [31:0] raw;
    } load_entry_t;

endpackage

// File: rtl/load_unit.sv
// Load extraction: picks the addressed byte/half of a raw RAM word, sign- or
// zero-extends it for writeback, and flags misaligned halves or unknown funct3.
module load_unit
    import riscv_mem_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] data_o,
    output logic        error_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        byte_sel = raw_i[7:0];
        case (offset_i)
            2'd1:    byte_sel = raw_i[15:8];
            2'd2:    byte_sel = raw_i[23:16];
            2'd3:    byte_sel = raw_i[31:24];
            default: byte_sel = raw_i[7:0];
        endcase
        half_sel = offset_i[1] ? raw_i[31:16] : raw_i[15:0];

        data_o  = raw_i;
        error_o = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data_o = {24'h0, byte_sel};
            F3_LH: begin
                data_o  = {{16{half_sel[15]}}, half_sel};
                error_o = offset_i[0];
            end
            F3_LHU: begin
                data_o  = {16'h0, half_sel};
                error_o = offset_i[0];
            end
            F3_LW:   data_o = raw_i;
            default: error_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Data-side memory responder: byte-enabled stores on the request edge, loads
// returned through a fixed-latency pipeline, aligned and extended for writeback.
module data_memory
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [29:0] memory_addr,
    input  logic [1:0]  byte_offset,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_in,
    input  logic [31:0] data_to_write,
    input  logic [3:0]  byte_enable,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic [4:0]  rd_out,
    output logic        mem_error
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem_q [DEPTH_WORDS];
    load_entry_t pipe_q [READ_LATENCY];
    load_entry_t entry_d;
    load_entry_t out_e;
    logic        write_err_q;
    logic        write_err_d;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [31:0] ext_data;
    logic        ext_err;

    assign in_range = {2'b00, memory_addr} < 32'(DEPTH_WORDS);
    assign idx      = memory_addr[AW-1:0];

    // NOTE: the RAM is deliberately left out of reset so it maps onto plain storage.
    always_ff @(posedge clk) begin
        if (write && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_enable[i]) mem_q[idx][8*i +: 8] <= data_to_write[8*i +: 8];
            end
        end
    end

    // A read colliding with a write is dropped; the write still goes ahead.
    always_comb begin
        entry_d     = '0;
        write_err_d = write && (!in_range || read);
        if (read && !write) begin
            entry_d.valid       = 1'b1;
            entry_d.addr_err    = !in_range;
            entry_d.tag.rd      = rd_in;
            entry_d.tag.funct3  = funct3;
            entry_d.tag.offset  = byte_offset;
            entry_d.raw         = in_range ? mem_q[idx] : 32'h0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage shifts on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
            write_err_q <= 1'b0;
        end else begin
            pipe_q[0] <= entry_d;
            for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            write_err_q <= write_err_d;
        end
    end

    assign out_e = pipe_q[READ_LATENCY-1];

    load_unit u_load_unit (
        .raw_i    (out_e.raw),
        .funct3_i (out_e.tag.funct3),
        .offset_i (out_e.tag.offset),
        .data_o   (ext_data),
        .error_o  (ext_err)
    );

    assign read_valid = out_e.valid;
    assign read_data  = ext_data;
    assign rd_out     = out_e.tag.rd;
    assign mem_error  = write_err_q || (out_e.valid && (out_e.addr_err || ext_err));

endmodule
